// File: rtl/pattern_scan_sched.sv
// pattern_scan_sched: round-robin scheduler feeding one shared bit-serial
// sequence detector. Each granted word is shifted MSB-first through the
// detector and the count of overlapping matches is returned with its ID.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for a requester; grants and captures word + config
// SHIFT  | one word bit per cycle into the history, counting matches
// REPORT | result held on res_* until the collector accepts it
module pattern_scan_sched #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = 2,
  parameter int CW    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_we,
  input  logic [WIDTH-1:0]      cfg_pattern,
  input  logic [3:0]            cfg_len,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  res_valid,
  output logic [IDW-1:0]        res_id,
  output logic [CW-1:0]         res_count,
  input  logic                  res_ready,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, REPORT} state_t;

  localparam logic [3:0] LEN_MAX = 4'(WIDTH);

  state_t           state, state_next;
  logic [WIDTH-1:0] cfg_pat_q, act_pat, word, hist, hist_next, mask, sel_word;
  logic [3:0]       cfg_len_q, act_len, len_clamped;
  logic [CW-1:0]    nbits, nbits_next, count;
  logic [IDW-1:0]   rr_ptr, ptr_next, sel, id_q;
  logic             any_valid, match, last_bit;
  int               idx;

  // Normalise the written length: 0 means 1, anything longer than a word
  // is cut to the word length, so the detector never sees an illegal len.
  always_comb begin
    len_clamped = cfg_len;
    if (cfg_len == 4'd0)
      len_clamped = 4'd1;
    else if (cfg_len > LEN_MAX)
      len_clamped = LEN_MAX;
  end

  // Round-robin pick: scan downward so the lowest offset from rr_ptr wins.
  always_comb begin
    any_valid = 1'b0;
    sel       = '0;
    idx       = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = (int'(rr_ptr) + i) % NREQ;
      if (req_valid[idx]) begin
        any_valid = 1'b1;
        sel       = IDW'(idx);
      end
    end
    sel_word = req_data[int'(sel)*WIDTH +: WIDTH];
    ptr_next = IDW'((int'(sel) + 1) % NREQ);
  end

  // Detector step: shift in the current MSB and test the low len bits.
  always_comb begin
    mask = '0;
    for (int j = 0; j < WIDTH; j++)
      mask[j] = (j < int'(act_len));
    hist_next  = {hist[WIDTH-2:0], word[WIDTH-1]};
    nbits_next = (nbits == CW'(WIDTH)) ? nbits : nbits + 1'b1;
    match      = (nbits_next >= CW'(act_len)) &&
                 ((hist_next & mask) == (act_pat & mask));
    last_bit   = (nbits_next == CW'(WIDTH));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next = state;
    req_ready  = '0;
    res_valid  = 1'b0;
    busy       = (state != IDLE);
    res_id     = id_q;
    res_count  = count;
    case (state)
      IDLE: begin
        if (any_valid) begin
          req_ready[sel] = 1'b1;
          state_next     = SHIFT;
        end
      end
      SHIFT: begin
        if (last_bit)
          state_next = REPORT;
      end
      REPORT: begin
        res_valid = 1'b1;
        if (res_ready)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Config, grant capture and the shifting datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_pat_q <= WIDTH'(5'b00110);
      cfg_len_q <= 4'd5;
      act_pat   <= '0;
      act_len   <= 4'd1;
      word      <= '0;
      hist      <= '0;
      nbits     <= '0;
      count     <= '0;
      id_q      <= '0;
      rr_ptr    <= '0;
    end else begin
      if (cfg_we) begin
        cfg_pat_q <= cfg_pattern;
        cfg_len_q <= len_clamped;
      end
      case (state)
        IDLE: begin
          if (any_valid) begin
            word    <= sel_word;
            id_q    <= sel;
            act_pat <= cfg_pat_q;
            act_len <= cfg_len_q;
            hist    <= '0;
            nbits   <= '0;
            count   <= '0;
            rr_ptr  <= ptr_next;
          end
        end
        SHIFT: begin
          word  <= {word[WIDTH-2:0], 1'b0};
          hist  <= hist_next;
          nbits <= nbits_next;
          if (match)
            count <= count + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_scan_sched.sv
// Bench for pattern_scan_sched: expected results are queued at each grant
// from a window-scanning reference model and compared by a result monitor.
module tb_pattern_scan_sched;
  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int IDW   = 2;
  localparam int CW    = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  cfg_we;
  logic [WIDTH-1:0]      cfg_pattern;
  logic [3:0]            cfg_len;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  res_valid;
  logic [IDW-1:0]        res_id;
  logic [CW-1:0]         res_count;
  logic                  res_ready;
  logic                  busy;

  int errors = 0;
  int checks = 0;

  logic [WIDTH-1:0] m_pat;
  int               m_len;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [CW-1:0]  cnt;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  pattern_scan_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .res_valid(res_valid), .res_id(res_id),
    .res_count(res_count), .res_ready(res_ready), .busy(busy)
  );

  function automatic int model_count(logic [WIDTH-1:0] w, logic [WIDTH-1:0] p, int len_raw);
    int l, n;
    bit hit;
    l = (len_raw < 1) ? 1 : ((len_raw > WIDTH) ? WIDTH : len_raw);
    n = 0;
    for (int s = 0; s <= WIDTH - l; s++) begin
      hit = 1'b1;
      for (int j = 0; j < l; j++)
        if (w[WIDTH-1-s-j] != p[l-1-j]) hit = 1'b0;
      if (hit) n++;
    end
    return n;
  endfunction

  // Result monitor: every accepted result must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: got id=%0d count=%0d, expected no result", res_id, res_count);
      end else begin
        mon_e = sb.pop_front();
        if ({res_id, res_count} !== {mon_e.id, mon_e.cnt}) begin
          errors++;
          $display("FAIL result: got id=%0d count=%0d, expected id=%0d count=%0d",
                   res_id, res_count, mon_e.id, mon_e.cnt);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic set_cfg(logic [WIDTH-1:0] p, int l);
    cfg_pattern = p;
    cfg_len     = 4'(l);
    cfg_we      = 1'b1;
    cyc();
    cfg_we = 1'b0;
    m_pat  = p;
    m_len  = l;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    cyc();
    rst   = 1'b0;
    m_pat = 8'b00110;
    m_len = 5;
  endtask

  // Returns in the cycle before the grant edge (sampled 3 time units in).
  task automatic wait_grant(output int gid, output bit ok);
    int k;
    ok  = 1'b0;
    gid = -1;
    k   = 0;
    while (!ok && k < 60) begin
      #1;
      if (req_ready != '0) begin
        ok = 1'b1;
        for (int i = 0; i < NREQ; i++)
          if (req_ready[i]) gid = i;
      end else begin
        @(posedge clk);
        #2;
        k++;
      end
    end
  endtask

  // From the grant cycle onward: wait until res_valid rises, return cycles taken.
  task automatic wait_result(input int start, output int lat);
    lat = start;
    while (res_valid !== 1'b1 && lat < 40) begin
      cyc();
      lat++;
    end
  endtask

  task automatic send_one(int req, logic [WIDTH-1:0] w, bit mid_cfg);
    int  gid, lat;
    bit  ok;
    req_data[req*WIDTH +: WIDTH] = w;
    req_valid = NREQ'(1) << req;
    wait_grant(gid, ok);
    checks++;
    if (!ok || gid != req || req_ready !== (NREQ'(1) << req)) begin
      errors++;
      $display("FAIL grant: got ready=%b id=%0d, expected ready=%b", req_ready, gid, NREQ'(1) << req);
      req_valid = '0;
      return;
    end
    sb.push_back('{id: IDW'(req), cnt: CW'(model_count(w, m_pat, m_len))});
    cyc();
    req_valid = '0;
    checks++;
    if (busy !== 1'b1 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL shift_state: got busy=%b res_valid=%b, expected busy=1 res_valid=0", busy, res_valid);
    end
    lat = 0;
    if (mid_cfg) begin
      set_cfg(8'b11, 2);
      lat = 1;
    end
    wait_result(lat, lat);
    checks++;
    if (lat != WIDTH) begin
      errors++;
      $display("FAIL latency: got %0d cycles, expected %0d", lat, WIDTH);
    end
    cyc();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc();
    cyc();
    checks++;
    if (req_ready !== '0 || res_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got ready=%b res_valid=%b busy=%b, expected 0 0 0", req_ready, res_valid, busy);
    end
    checks++;
    if (res_id !== '0 || res_count !== '0) begin
      errors++;
      $display("FAIL reset_res: got id=%0d count=%0d, expected 0 0", res_id, res_count);
    end
    rst   = 1'b0;
    m_pat = 8'b00110;
    m_len = 5;
    cyc();
  endtask

  task automatic test_default_pattern();
    send_one(2, 8'h33, 1'b0);
    send_one(2, 8'h19, 1'b0);
    send_one(2, 8'hFF, 1'b0);
  endtask

  task automatic test_lengths();
    set_cfg(8'b11, 2);
    send_one(1, 8'hFF, 1'b0);
    set_cfg(8'h01, 0);
    send_one(3, 8'hFF, 1'b0);
    set_cfg(8'h06, 12);
    send_one(0, 8'h06, 1'b0);
    send_one(0, 8'h60, 1'b0);
  endtask

  task automatic test_round_robin();
    int gid, lat;
    bit ok;
    logic [WIDTH-1:0] words [NREQ];
    words[0] = 8'h33; words[1] = 8'h19; words[2] = 8'hC6; words[3] = 8'h0C;
    pulse_reset();
    for (int i = 0; i < NREQ; i++) req_data[i*WIDTH +: WIDTH] = words[i];
    req_valid = '1;
    for (int g = 0; g < 5; g++) begin
      wait_grant(gid, ok);
      checks++;
      if (!ok || gid != (g % NREQ)) begin
        errors++;
        $display("FAIL rr_order: grant %0d got id=%0d, expected %0d", g, gid, g % NREQ);
      end
      if (ok && gid >= 0)
        sb.push_back('{id: IDW'(gid), cnt: CW'(model_count(words[gid], m_pat, m_len))});
      cyc();
      if (g == 4) req_valid = '0;
      wait_result(0, lat);
      cyc();
    end
  endtask

  task automatic test_backpressure();
    int gid, lat;
    bit ok;
    int exp_cnt;
    res_ready = 1'b0;
    req_data[1*WIDTH +: WIDTH] = 8'h66;
    req_valid = 4'b0010;
    wait_grant(gid, ok);
    exp_cnt = model_count(8'h66, m_pat, m_len);
    if (ok) sb.push_back('{id: IDW'(1), cnt: CW'(exp_cnt)});
    cyc();
    req_data[3*WIDTH +: WIDTH] = 8'hFF;
    req_valid = 4'b1000;
    wait_result(0, lat);
    for (int c = 0; c < 5; c++) begin
      cyc();
      #1;
      checks++;
      if (res_valid !== 1'b1 || res_id !== IDW'(1) || res_count !== CW'(exp_cnt) || req_ready !== '0) begin
        errors++;
        $display("FAIL hold: cycle %0d got valid=%b id=%0d count=%0d ready=%b, expected 1 1 %0d 0000",
                 c, res_valid, res_id, res_count, req_ready, exp_cnt);
      end
    end
    #1;
    res_ready = 1'b1;
    cyc();
    #1;
    checks++;
    if (res_valid !== 1'b0 || req_ready !== 4'b1000) begin
      errors++;
      $display("FAIL release: got valid=%b ready=%b, expected valid=0 ready=1000", res_valid, req_ready);
    end
    sb.push_back('{id: IDW'(3), cnt: CW'(model_count(8'hFF, m_pat, m_len))});
    cyc();
    req_valid = '0;
    wait_result(0, lat);
    cyc();
  endtask

  task automatic test_cfg_in_flight();
    send_one(0, 8'h33, 1'b1);
    send_one(0, 8'h33, 1'b0);
  endtask

  task automatic test_reset_mid_shift();
    int gid, lat;
    bit ok;
    int quiet;
    set_cfg(8'b11, 2);
    req_data[2*WIDTH +: WIDTH] = 8'h33;
    req_valid = 4'b0100;
    wait_grant(gid, ok);
    cyc();
    req_valid = '0;
    cyc();
    cyc();
    pulse_reset();
    checks++;
    if (busy !== 1'b0 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_shift: got busy=%b res_valid=%b, expected 0 0", busy, res_valid);
    end
    quiet = 1;
    for (int c = 0; c < 12; c++) begin
      cyc();
      if (res_valid !== 1'b0 || busy !== 1'b0) quiet = 0;
    end
    checks++;
    if (quiet != 1) begin
      errors++;
      $display("FAIL reset_discard: got activity after reset, expected idle");
    end
    req_data[0*WIDTH +: WIDTH] = 8'h33;
    req_data[3*WIDTH +: WIDTH] = 8'h33;
    req_valid = 4'b1001;
    wait_grant(gid, ok);
    checks++;
    if (!ok || gid != 0) begin
      errors++;
      $display("FAIL reset_rr_ptr: got id=%0d, expected 0", gid);
    end
    if (ok && gid >= 0)
      sb.push_back('{id: IDW'(gid), cnt: CW'(model_count(8'h33, 8'b00110, 5))});
    cyc();
    req_valid = '0;
    wait_result(0, lat);
    cyc();
  endtask

  initial begin
    rst         = 1'b1;
    cfg_we      = 1'b0;
    cfg_pattern = '0;
    cfg_len     = '0;
    req_valid   = '0;
    req_data    = '0;
    res_ready   = 1'b1;
    m_pat       = 8'b00110;
    m_len       = 5;

    test_reset();
    test_default_pattern();
    test_lengths();
    test_round_robin();
    set_cfg(8'b00110, 5);
    test_backpressure();
    test_cfg_in_flight();
    test_reset_mid_shift();

    cyc();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL leftover: got %0d pending expected results, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
